// File: rtl/alu_seq.sv
// Multi-word sequencer for a shared external ALU: accepts a command, streams
// operand pairs LS word first, chains carry/borrow across words, returns results.
module alu_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_op,
  input  logic [1:0]       cmd_len,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_w,
  output logic             alu_cin,
  output logic [SEL_W-1:0] alu_s,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic             carry_flag
);

  localparam int unsigned LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_ADC = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SBB = SEL_W'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [SEL_W-1:0] op_q;
  logic [1:0]       len_q;
  logic             cin_q;
  logic [1:0]       word_q;
  logic [LAT_W-1:0] lat_q;
  logic             carry_q;

  logic             cmd_fire;
  logic             in_fire;
  logic             exec_end;
  logic             out_fire;
  logic             is_last;
  logic [SEL_W-1:0] alu_s_d;
  logic             alu_cin_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake strobes and per-word ALU select/carry
  always_comb begin
    state_d   = state_q;
    cmd_fire  = 1'b0;
    in_fire   = 1'b0;
    exec_end  = 1'b0;
    out_fire  = 1'b0;
    is_last   = (word_q == len_q);
    alu_s_d   = op_q;
    alu_cin_d = cin_q;

    // Upper words of an add/subtract chain the previous word's carry/borrow
    if (word_q != 2'd0) begin
      if (op_q == OP_ADD || op_q == OP_ADC) begin
        alu_s_d   = OP_ADC;
        alu_cin_d = carry_q;
      end else if (op_q == OP_SUB || op_q == OP_SBB) begin
        alu_s_d   = OP_SBB;
        alu_cin_d = carry_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_fire = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          in_fire = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_q == LAT_LAST) begin
          exec_end = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = is_last ? S_IDLE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      len_q      <= '0;
      cin_q      <= 1'b0;
      word_q     <= '0;
      lat_q      <= '0;
      carry_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      alu_a      <= '0;
      alu_w      <= '0;
      alu_cin    <= 1'b0;
      alu_s      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      cmd_ready <= (state_d == S_IDLE);
      in_ready  <= (state_d == S_LOAD);
      out_valid <= (state_d == S_OUT);
      busy      <= (state_d != S_IDLE);
      done      <= 1'b0;

      if (cmd_fire) begin
        op_q   <= cmd_op;
        len_q  <= cmd_len;
        cin_q  <= cmd_cin;
        word_q <= '0;
      end

      if (in_fire) begin
        alu_a   <= in_a;
        alu_w   <= in_w;
        alu_s   <= alu_s_d;
        alu_cin <= alu_cin_d;
        lat_q   <= '0;
      end else if (state_q == S_EXEC) begin
        lat_q <= lat_q + LAT_W'(1);
      end

      if (exec_end) begin
        out_data <= alu_d;
        out_last <= is_last;
        carry_q  <= alu_cout;
      end

      if (out_fire) begin
        if (is_last) begin
          done       <= 1'b1;
          carry_flag <= carry_q;
        end else begin
          word_q <= word_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: unit 0 uses a combinational ALU (ALU_LAT=0),
// unit 1 a two-cycle-delayed ALU (ALU_LAT=2); results checked via a scoreboard.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [2:0] cmd_op    [2];
  logic [1:0] cmd_len   [2];
  logic       cmd_cin   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_a      [2];
  logic [7:0] in_w      [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       out_last  [2];
  logic [7:0] alu_a     [2];
  logic [7:0] alu_w     [2];
  logic       alu_cin   [2];
  logic [2:0] alu_s     [2];
  logic [7:0] alu_d     [2];
  logic       alu_cout  [2];
  logic       busy      [2];
  logic       done      [2];
  logic       carry_flag[2];

  always #5 clk = ~clk;

  // Reference ALU: {cout, d}; subtract carry is the borrow out of bit 7
  function automatic logic [8:0] alu_m(input logic [2:0] s, input logic [7:0] a,
                                       input logic [7:0] w, input logic c);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, w};
      3'd4:    return {1'b0, a} + {1'b0, w} + 9'(c);
      3'd1:    return {1'b0, a} - {1'b0, w};
      3'd5:    return {1'b0, a} - {1'b0, w} - 9'(c);
      3'd2:    return {1'b0, a | w};
      3'd3:    return {1'b0, a & w};
      3'd6:    return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [8:0] m_now;
    assign m_now = alu_m(alu_s[g], alu_a[g], alu_w[g], alu_cin[g]);
    if (g == 0) begin : g_comb
      assign {alu_cout[g], alu_d[g]} = m_now;
    end else begin : g_dly
      logic [8:0] p0;
      logic [8:0] p1;
      always @(posedge clk) begin
        p0 <= m_now;
        p1 <= p0;
      end
      assign {alu_cout[g], alu_d[g]} = p1;
    end

    alu_seq #(.WIDTH(8), .SEL_W(3), .ALU_LAT(g * 2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_len   (cmd_len[g]),
      .cmd_cin   (cmd_cin[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_w      (in_w[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .alu_a     (alu_a[g]),
      .alu_w     (alu_w[g]),
      .alu_cin   (alu_cin[g]),
      .alu_s     (alu_s[g]),
      .alu_d     (alu_d[g]),
      .alu_cout  (alu_cout[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .carry_flag(carry_flag[g])
    );
  end

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [2:0] s;
    logic       cin;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  logic exp_cf[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every output in its reset value; cmd_ready already high
  task automatic chk_reset(input int u, input string tag);
    chk(tag, {out_data[u], out_valid[u], out_last[u], done[u], busy[u], carry_flag[u],
              alu_a[u], alu_w[u], alu_cin[u], alu_s[u], cmd_ready[u], in_ready[u]}, 64'd2);
  endtask

  // Whole multi-word operation on nb bits; bit nb is the final carry/borrow
  function automatic logic [39:0] wide(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin, input int nb);
    logic [39:0] m;
    logic [39:0] x;
    logic [39:0] y;
    m = (40'd1 << nb) - 40'd1;
    x = {8'd0, a} & m;
    y = {8'd0, b} & m;
    case (op)
      3'd0:    return x + y;
      3'd4:    return x + y + 40'(cin);
      3'd1:    return x - y;
      3'd5:    return x - y - 40'(cin);
      3'd2:    return x | y;
      3'd3:    return x & y;
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic run_cmd(input int u, input logic [2:0] op, input logic [1:0] len,
                         input logic cin, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit intrude, input int abort_w);
    int          nb;
    int          t;
    int          nw;
    logic [39:0] r;
    logic [39:0] rl;
    logic        arith;
    logic        cf;
    exp_t        e;
    nw    = int'(len) + 1;
    nb    = 8 * nw;
    r     = wide(op, a, b, cin, nb);
    arith = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
    cf    = arith ? r[nb] : 1'b0;
    for (int i = 0; i < nw; i++) begin
      e.d    = r[8*i +: 8];
      e.last = (i == nw - 1);
      e.s    = op;
      e.cin  = cin;
      if (i > 0 && arith) begin
        rl    = wide(op, a, b, cin, 8 * i);
        e.s   = (op == 3'd0 || op == 3'd4) ? 3'd4 : 3'd5;
        e.cin = rl[8*i];
      end
      sb.push_back(e);
    end

    chk("carry_flag_hold", carry_flag[u], exp_cf[u]);
    t = 0;
    while (cmd_ready[u] !== 1'b1 && t < 20) begin tick(); t++; end
    chk("cmd_ready_wait", t, 0);
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_len[u]   = len;
    cmd_cin[u]   = cin;
    tick();
    cmd_valid[u] = 1'b0;
    if (intrude) begin
      cmd_valid[u] = 1'b1;
      cmd_op[u]    = 3'd2;
    end

    for (int i = 0; i < nw; i++) begin
      if (i == nw - 1) cmd_valid[u] = 1'b0;
      t = 0;
      while (in_ready[u] !== 1'b1 && t < 20) begin tick(); t++; end
      chk("load_wait", t < 20, 1);
      chk("busy_no_cmd", {cmd_ready[u], busy[u]}, 2'b01);
      if (i == abort_w) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd_valid[u] = 1'b0;
        chk_reset(u, "abort_reset");
        sb.delete();
        exp_cf[0] = 1'b0;
        exp_cf[1] = 1'b0;
        return;
      end
      in_valid[u] = 1'b1;
      in_a[u]     = a[8*i +: 8];
      in_w[u]     = b[8*i +: 8];
      tick();
      in_valid[u] = 1'b0;
      e = sb[0];
      chk("alu_s", alu_s[u], e.s);
      chk("alu_cin", alu_cin[u], e.cin);
      t = 0;
      while (out_valid[u] !== 1'b1 && t < 20) begin tick(); t++; end
      chk("exec_cycles", t, u * 2 + 1);
      for (int k = 0; k < stall; k++) begin
        chk("stall_stable", {out_valid[u], in_ready[u], cmd_ready[u], out_data[u], out_last[u]},
            {1'b1, 1'b0, 1'b0, e.d, e.last});
        tick();
      end
      chk("out_data", out_data[u], e.d);
      chk("out_last", out_last[u], e.last);
      out_ready[u] = 1'b1;
      tick();
      out_ready[u] = 1'b0;
      void'(sb.pop_front());
      if (i == nw - 1) begin
        chk("done_pulse", done[u], 1);
        chk("carry_flag", carry_flag[u], cf);
        exp_cf[u] = cf;
        tick();
        chk("idle_after_done", {done[u], busy[u], cmd_ready[u], carry_flag[u]}, {3'b001, cf});
      end else begin
        chk("no_early_done", done[u], 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0;
      cmd_op[u]    = '0;
      cmd_len[u]   = '0;
      cmd_cin[u]   = 1'b0;
      in_valid[u]  = 1'b0;
      in_a[u]      = '0;
      in_w[u]      = '0;
      out_ready[u] = 1'b0;
      exp_cf[u]    = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    chk_reset(0, "reset_u0");
    chk_reset(1, "reset_u1");

    run_cmd(0, 3'd0, 2'd0, 1'b0, 32'h12, 32'h34, 0, 0, -1);
    run_cmd(0, 3'd0, 2'd1, 1'b0, 32'h01FF, 32'h0001, 0, 0, -1);
    run_cmd(0, 3'd1, 2'd0, 1'b0, 32'h10, 32'h20, 5, 0, -1);
    run_cmd(0, 3'd4, 2'd2, 1'b1, $urandom, $urandom, 0, 1, -1);
    run_cmd(0, 3'd5, 2'd3, 1'b1, $urandom, $urandom, 0, 0, -1);
    run_cmd(0, 3'd0, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h1, 1, 0, -1);
    run_cmd(0, 3'd2, 2'd3, 1'b1, $urandom, $urandom, 0, 0, -1);
    run_cmd(0, 3'd1, 2'd2, 1'b1, 32'h000100, 32'h000001, 0, 0, -1);
    run_cmd(0, 3'd3, 2'd1, 1'b0, $urandom, $urandom, 0, 0, -1);
    run_cmd(0, 3'd6, 2'd2, 1'b1, $urandom, $urandom, 0, 0, -1);
    run_cmd(0, 3'd7, 2'd0, 1'b0, 32'hA5, 32'h3C, 0, 0, -1);
    run_cmd(0, 3'd0, 2'd2, 1'b0, $urandom, $urandom, 0, 0, 1);
    run_cmd(0, 3'd0, 2'd0, 1'b0, 32'h80, 32'h80, 0, 0, -1);

    run_cmd(1, 3'd0, 2'd1, 1'b0, $urandom, $urandom, 0, 0, -1);
    run_cmd(1, 3'd5, 2'd2, 1'b1, $urandom, $urandom, 2, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result word width.
REQ-002 Parameter SEL_W, default 3, ALU opcode select width.
REQ-003 Parameter ALU_LAT, default 0, extra cycles the ALU result needs to settle after its inputs change (0..7).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high at a rising edge.
REQ-007 cmd_op  in  SEL_W  opcode: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 ADC, 5 SBB, 6 NOT, 7 PASS.
REQ-008 cmd_len  in  2  word count minus 1 (1..4 words); cmd_cin  in  1  initial carry/borrow.
REQ-009 in_valid/in_ready  in/out  1/1  operand-pair handshake; in_a, in_w  in  WIDTH each, least-significant word first.
REQ-010 out_valid/out_ready  out/in  1/1  result handshake; out_data  out  WIDTH; out_last  out  1, high on the final word.
REQ-011 alu_a, alu_w  out  WIDTH; alu_cin  out  1; alu_s  out  SEL_W: drive the shared ALU.
REQ-012 alu_d  in  WIDTH; alu_cout  in  1: ALU result and carry.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); carry_flag  out  1 (final carry of the last command).

Function
REQ-014 FSM states are IDLE, LOAD, EXEC and OUT; all outputs are registered or decoded from state only.
REQ-015 IDLE: cmd_ready=1; on a command transfer, latch op, len, cin, clear word counter, go to LOAD.
REQ-016 LOAD: in_ready=1; on an operand transfer, latch in_a/in_w, go to EXEC; stay in LOAD otherwise.
REQ-017 EXEC: lasts exactly ALU_LAT+1 cycles; alu_a/alu_w come from the latched operands; at the last EXEC edge capture alu_d into out_data and alu_cout into an internal carry register, then go to OUT.
REQ-018 Word 0 drives alu_s=cmd_op and alu_cin=cmd_cin.
REQ-019 For words 1..len, ADD/ADC drive alu_s=4 (ADC) and SUB/SBB drive alu_s=5 (SBB), with alu_cin=the internal carry register.
REQ-020 For words 1..len, OR/AND/NOT/PASS keep alu_s=cmd_op and alu_cin=cmd_cin.
REQ-021 alu_* outputs hold their last values outside EXEC; their value there carries no meaning.
REQ-022 OUT: out_valid=1; out_data and out_last stay stable until out_ready=1.
REQ-023 On an OUT transfer with word counter == len: go to IDLE, pulse done for one cycle, and load carry_flag from the internal carry register.
REQ-024 On any other OUT transfer: increment the counter and go to LOAD.
REQ-025 busy=1 in every state except IDLE.
REQ-026 cmd_ready=0 outside IDLE; cmd_valid is ignored while busy.
REQ-027 in_ready=0 outside LOAD.
REQ-028 Minimum cost is ALU_LAT+3 cycles per word; a new command may be accepted the cycle after done.
REQ-029 The word counter never wraps: len=3 yields exactly 4 words.
REQ-030 carry_flag holds between commands and changes only at command completion.

Reset
REQ-031 While rst=1 at a rising edge: state=IDLE; the counter, latched command, operands and internal carry are cleared.
REQ-032 Also while rst=1: out_data=0, out_valid=0, out_last=0, done=0, busy=0, carry_flag=0, alu_a=0, alu_w=0, alu_cin=0, alu_s=0.
REQ-033 In any state, reset aborts the command in progress with no done pulse and no carry_flag update; cmd_ready=1 on the first cycle after rst falls.

Verification (WIDTH=8; the ALU model computes ADD a+w, ADC a+w+cin, and cout = bit 8)
REQ-034 Single ADD, len=0, cin=0, operands 0x12/0x34 -> alu_s=0, out_data=0x46, out_last=1, carry_flag=0, done pulses once.
REQ-035 Two-word ADD, operands (0xFF,0x01) then (0x01,0x00) -> word 0 alu_s=0 and out_data 0x00; word 1 alu_s=4, alu_cin=1, out_data 0x02; carry_flag=0.
REQ-036 out_ready held low 5 cycles in OUT -> out_data/out_valid stable, in_ready=0, cmd_ready=0; the transfer completes on the first out_ready=1.
REQ-037 cmd_valid=1 with a different op during a busy 3-word command -> not accepted, results unchanged.
REQ-038 rst asserted in LOAD of word 1 of 3 -> all outputs match REQ-031/REQ-032 next cycle, no done; a following single ADD completes correctly.
REQ-039 ALU_LAT=2 with the ALU model delayed 2 cycles -> EXEC lasts 3 cycles and out_data equals the settled result.
